// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response bundle between decode, alu_seq and writeback
interface alu_seq_if #(
   parameter int WIDTH = 16,
   parameter int IMM_W = 9
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] rn;
   logic [WIDTH-1:0] rm;
   logic [IMM_W-1:0] imm;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] rd;
   logic             z;
   logic             n;
   logic             c;
   logic             v;
   logic             err;
   logic             busy;

   modport master (
      output in_valid, op, rn, rm, imm, out_ready,
      input  in_ready, out_valid, rd, z, n, c, v, err, busy
   );

   modport slave (
      input  in_valid, op, rn, rm, imm, out_ready,
      output in_ready, out_valid, rd, z, n, c, v, err, busy
   );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with flags and iterative shift-add multiply
// One op per handshake; MUL spends WIDTH cycles in BUSY, everything else completes in one.
module alu_seq #(
   parameter int  WIDTH = 16,
   parameter int  IMM_W = 9,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic      clk,
   input  logic      rst_n,
   alu_seq_if.slave  bus
);
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_MOV  = 4'd5;
   localparam logic [3:0] OP_ZEXT = 4'd6;
   localparam logic [3:0] OP_SEXT = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;
   localparam logic [3:0] OP_ASR  = 4'd10;
   localparam logic [3:0] OP_MUL  = 4'd11;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_rd;
   logic               r_z, r_n, r_c, r_v, r_err;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mcand;
   logic [SHW-1:0]     r_cnt;

   logic               w_in_ready, w_out_valid, w_busy;
   logic               w_in_fire, w_is_mul, w_mul_last;
   logic [WIDTH-1:0]   w_b, w_res;
   logic [WIDTH:0]     w_sum;
   logic [SHW-1:0]     w_amt;
   logic               w_c, w_v, w_err;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_next;

   assign w_is_mul   = (bus.op == OP_MUL);
   assign w_in_fire  = bus.in_valid && w_in_ready;
   assign w_mul_last = (r_state == S_BUSY) && (r_cnt == SHW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_next = w_is_mul ? S_BUSY : S_DONE;
         end
         S_BUSY: begin
            w_busy = 1'b1;
            if (w_mul_last) w_next = S_DONE;
         end
         S_DONE: begin
            w_out_valid = 1'b1;
            w_in_ready  = bus.out_ready;
            if (bus.out_ready) begin
               if (bus.in_valid) w_next = w_is_mul ? S_BUSY : S_DONE;
               else              w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // SUB reuses the adder as rn + ~rm + 1 so carry-out means "no borrow"
   always_comb begin
      w_b   = (bus.op == OP_SUB) ? ~bus.rm : bus.rm;
      w_sum = {1'b0, bus.rn} + {1'b0, w_b} + {{WIDTH{1'b0}}, (bus.op == OP_SUB)};
      w_amt = bus.rm[SHW-1:0];
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      w_err = 1'b0;
      case (bus.op)
         OP_ADD, OP_SUB: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (bus.rn[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.rn[WIDTH-1]);
         end
         OP_AND:  w_res = bus.rn & bus.rm;
         OP_OR:   w_res = bus.rn | bus.rm;
         OP_XOR:  w_res = bus.rn ^ bus.rm;
         OP_MOV:  w_res = bus.rn;
         OP_ZEXT: w_res = {{(WIDTH-IMM_W){1'b0}}, bus.imm};
         OP_SEXT: w_res = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
         OP_SHL:  w_res = bus.rn << w_amt;
         OP_SHR:  w_res = bus.rn >> w_amt;
         OP_ASR:  w_res = $signed(bus.rn) >>> w_amt;
         OP_MUL:  w_res = '0;
         default: w_err = 1'b1;
      endcase
   end

   // Product register: upper half accumulates, lower half holds the multiplier being shifted out
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd    <= '0;
         r_z     <= 1'b0;
         r_n     <= 1'b0;
         r_c     <= 1'b0;
         r_v     <= 1'b0;
         r_err   <= 1'b0;
         r_acc   <= '0;
         r_mcand <= '0;
         r_cnt   <= '0;
      end else begin
         if (w_in_fire && w_is_mul) begin
            r_acc   <= {{WIDTH{1'b0}}, bus.rm};
            r_mcand <= bus.rn;
            r_cnt   <= '0;
         end else if (r_state == S_BUSY) begin
            r_acc <= w_mul_next;
            r_cnt <= r_cnt + SHW'(1);
         end
         if (w_in_fire && !w_is_mul) begin
            r_rd  <= w_res;
            r_z   <= (w_res == '0);
            r_n   <= w_res[WIDTH-1];
            r_c   <= w_c;
            r_v   <= w_v;
            r_err <= w_err;
         end else if (w_mul_last) begin
            r_rd  <= w_mul_next[WIDTH-1:0];
            r_z   <= (w_mul_next[WIDTH-1:0] == '0);
            r_n   <= w_mul_next[WIDTH-1];
            r_c   <= |w_mul_next[2*WIDTH-1:WIDTH];
            r_v   <= 1'b0;
            r_err <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.busy      = w_busy;
   assign bus.rd        = r_rd;
   assign bus.z         = r_z;
   assign bus.n         = r_n;
   assign bus.c         = r_c;
   assign bus.v         = r_v;
   assign bus.err       = r_err;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the team's combinational ALU. Accepts one operation per valid/ready handshake and returns a registered result with Z/N/C/V flags. Adds XOR, shifts and an iterative multi-cycle multiply. Sits between the decode stage and the register-file writeback.

Parameters:
WIDTH, 16, datapath width in bits (>=4, power of two)
IMM_W, 9, immediate field width (< WIDTH)
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept an operation this cycle
op  in  4  operation code (below)
rn  in  WIDTH  operand A
rm  in  WIDTH  operand B
imm  in  IMM_W  immediate field
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
rd  out  WIDTH  result
z  out  1  rd == 0
n  out  1  rd[WIDTH-1]
c  out  1  carry / multiply high-half flag
v  out  1  signed overflow
err  out  1  illegal op code for this result
busy  out  1  multiply in progress

Behaviour:
- Op codes:
  - 0 ADD: rn+rm
  - 1 SUB: rn+~rm+1
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 MOV: rd=rn
  - 6 ZEXT: imm zero-extended
  - 7 SEXT: imm sign-extended from imm[IMM_W-1]
  - 8 SHL: rn<<rm[SHW-1:0]
  - 9 SHR: logical
  - 10 ASR: arithmetic
  - 11 MUL: low WIDTH bits of rn*rm, unsigned
  - 12-15: illegal, rd=0, err=1
- Flags:
  - z and n are computed from the final rd for every op.
  - ADD: c = carry-out. SUB: c = carry-out of rn+~rm+1 (1 = no borrow).
  - ADD/SUB: v = signed overflow.
  - MUL: c = 1 iff the upper WIDTH bits of the 2*WIDTH product are nonzero; v=0.
  - All other ops: c=v=0.
- Handshake:
  - Input transfers when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - Operands are sampled only at the input transfer; later input changes are ignored.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - Transfer of a non-MUL op -> DONE, with result registered at the same edge.
    - Transfer of MUL -> BUSY.
  - BUSY: in_ready=0, busy=1. Shift-add, one multiplier bit per cycle, 2*WIDTH accumulator, iteration counter 0..WIDTH-1. After WIDTH cycles -> DONE with rd/flags loaded.
  - DONE: out_valid=1; rd/z/n/c/v/err held stable until transfer. in_ready = out_ready.
    - Output transfer plus simultaneous input transfer of a non-MUL op -> stay DONE with new result (back-to-back throughput of 1/cycle).
    - Output transfer plus simultaneous MUL -> BUSY.
    - Output transfer with no input -> IDLE.
- Latency (input transfer edge T):
  - Non-MUL: out_valid at T+1.
  - MUL: out_valid at T+WIDTH+1.
- Shift amount uses only rm[SHW-1:0]; upper rm bits are ignored. Shift by 0 returns rn.
- Reset (asynchronous, any state including mid-multiply):
  - State -> IDLE; rd, z, n, c, v, err, busy, out_valid, accumulator and counter cleared.
  - in_ready=1 once rst_n deasserts.
  - The aborted multiply produces no output.
- out_valid never drops without an output transfer. rd/flags never change while out_valid=1 && !out_ready.
- No X on outputs after reset. Illegal op codes raise err only and never hang the FSM.

Test Plan:
- WIDTH=16, ADD rn=0x7FFF, rm=0x0001, out_ready=1 -> next cycle rd=0x8000, n=1, v=1, c=0, z=0. Then SUB 0x1234-0x1234 -> rd=0, z=1, c=1, v=0.
- SEXT imm=9'h1F0 -> rd=0xFFF0, n=1. ZEXT imm=9'h1F0 -> rd=0x01F0. ASR rn=0x8000, rm=0x0013 (amount 3) -> rd=0xF000. SHR same operands -> rd=0x1000.
- MUL rn=300, rm=300 -> busy=1 for 16 cycles, in_ready=0. out_valid at T+17 with rd=0x5F90 and c=1. MUL 3*5 -> rd=15, c=0.
- Backpressure: ADD issued with out_ready=0 for 5 cycles -> rd/flags stable and in_ready=0. Raise out_ready together with a new in_valid (XOR) -> both transfer in the same cycle; the XOR result appears the next cycle.
- Pull rst_n low at the 8th BUSY cycle of a MUL -> all outputs 0 immediately, in_ready=1 after release, no stale out_valid.
- op=13 -> rd=0, err=1, z=1. The following legal op clears err.
